iact_weight_grid_feeder: RTL and testbench



---
 rtl/iact_weight_grid_feeder.sv | 123 ++++++++++++
 tb/tb_iact_weight_grid_feeder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iact_weight_grid_feeder.sv
// Packs a mixed iact/weight word stream into full-width iact and weight vectors for the PE grid.
// Each packer fills slice by slice, then holds its vector until the grid buffer takes it.
module iact_weight_grid_feeder #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned IFMAP_COUNT = 5,
    parameter int unsigned ARRAY_WIDTH = 3,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic                              in_sel,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              in_ready,
    input  logic                              flush,
    input  logic                              iact_buffer_ready,
    input  logic                              weight_buffer_ready,
    output logic [DATA_WIDTH*IFMAP_COUNT-1:0] data_iact_out,
    output logic                              iact_write_en,
    output logic [DATA_WIDTH*ARRAY_WIDTH-1:0] data_weight_out,
    output logic                              weight_write_en,
    output logic [CNT_WIDTH-1:0]              iact_vec_cnt,
    output logic [CNT_WIDTH-1:0]              weight_vec_cnt
);

    localparam int unsigned IFW = (IFMAP_COUNT > 1) ? $clog2(IFMAP_COUNT) : 1;
    localparam int unsigned WFW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;

    typedef enum logic {StFill, StIssue} state_e;

    state_e                              ist_q, ist_d, wst_q, wst_d;
    logic [IFW-1:0]                      ifill_q, ifill_d;
    logic [WFW-1:0]                      wfill_q, wfill_d;
    logic [DATA_WIDTH*IFMAP_COUNT-1:0]   idata_q, idata_d;
    logic [DATA_WIDTH*ARRAY_WIDTH-1:0]   wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]                icnt_q, icnt_d, wcnt_q, wcnt_d;
    logic                                i_accept, w_accept, i_xfer, w_xfer;

    // rst gates in_ready so nothing is accepted in the reset cycle.
    always_comb begin
        in_ready = ~rst & ~flush & (in_sel ? (wst_q == StFill) : (ist_q == StFill));
        i_accept = in_valid & in_ready & ~in_sel;
        w_accept = in_valid & in_ready & in_sel;
        i_xfer   = (ist_q == StIssue) & iact_buffer_ready;
        w_xfer   = (wst_q == StIssue) & weight_buffer_ready;
    end

    always_comb begin
        ist_d   = ist_q;
        ifill_d = ifill_q;
        idata_d = idata_q;
        icnt_d  = icnt_q;
        if (flush) ifill_d = '0;
        if (i_accept) begin
            for (int unsigned k = 0; k < IFMAP_COUNT; k++) begin
                if (ifill_q == IFW'(k)) idata_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
            if (ifill_q == IFW'(IFMAP_COUNT - 1)) begin
                ifill_d = '0;
                ist_d   = StIssue;
            end else begin
                ifill_d = ifill_q + IFW'(1);
            end
        end
        if (i_xfer) begin
            ist_d  = StFill;
            icnt_d = icnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        wst_d   = wst_q;
        wfill_d = wfill_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;
        if (flush) wfill_d = '0;
        if (w_accept) begin
            for (int unsigned k = 0; k < ARRAY_WIDTH; k++) begin
                if (wfill_q == WFW'(k)) wdata_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
            if (wfill_q == WFW'(ARRAY_WIDTH - 1)) begin
                wfill_d = '0;
                wst_d   = StIssue;
            end else begin
                wfill_d = wfill_q + WFW'(1);
            end
        end
        if (w_xfer) begin
            wst_d  = StFill;
            wcnt_d = wcnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ist_q   <= StFill;
            wst_q   <= StFill;
            ifill_q <= '0;
            wfill_q <= '0;
            idata_q <= '0;
            wdata_q <= '0;
            icnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            ist_q   <= ist_d;
            wst_q   <= wst_d;
            ifill_q <= ifill_d;
            wfill_q <= wfill_d;
            idata_q <= idata_d;
            wdata_q <= wdata_d;
            icnt_q  <= icnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign data_iact_out   = idata_q;
    assign data_weight_out = wdata_q;
    assign iact_write_en   = (ist_q == StIssue);
    assign weight_write_en = (wst_q == StIssue);
    assign iact_vec_cnt    = icnt_q;
    assign weight_vec_cnt  = wcnt_q;

endmodule

// File: tb/tb_iact_weight_grid_feeder.sv
// Bench for iact_weight_grid_feeder: a directed cycle table, hand sequences for flush/reset/wrap,
// and random traffic checked every cycle against a queue-based reference model.
module tb_iact_weight_grid_feeder;

    localparam int DW = 16;
    localparam int IC = 5;
    localparam int AW = 3;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_sel, in_ready, flush;
    logic              iact_buffer_ready, weight_buffer_ready;
    logic [DW-1:0]     in_data;
    logic [DW*IC-1:0]  data_iact_out;
    logic [DW*AW-1:0]  data_weight_out;
    logic              iact_write_en, weight_write_en;
    logic [CW-1:0]     iact_vec_cnt, weight_vec_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: words collected in queues, completed vectors held as pending.
    logic [DW-1:0]    m_iq[$];
    logic [DW-1:0]    m_wq[$];
    logic             m_ipend, m_wpend;
    logic [DW*IC-1:0] m_ivec;
    logic [DW*AW-1:0] m_wvec;
    int               m_icnt, m_wcnt;

    always #5 clk = ~clk;

    iact_weight_grid_feeder dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_sel              (in_sel),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .flush               (flush),
        .iact_buffer_ready   (iact_buffer_ready),
        .weight_buffer_ready (weight_buffer_ready),
        .data_iact_out       (data_iact_out),
        .iact_write_en       (iact_write_en),
        .data_weight_out     (data_weight_out),
        .weight_write_en     (weight_write_en),
        .iact_vec_cnt        (iact_vec_cnt),
        .weight_vec_cnt      (weight_vec_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic exp_rdy;
        exp_rdy = !rst && !flush && (in_sel ? !m_wpend : !m_ipend);
        chk("model_in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("model_iact_we", 128'(iact_write_en), 128'(m_ipend));
        chk("model_weight_we", 128'(weight_write_en), 128'(m_wpend));
        if (m_ipend) chk("model_iact_bus", 128'(data_iact_out), 128'(m_ivec));
        if (m_wpend) chk("model_weight_bus", 128'(data_weight_out), 128'(m_wvec));
        chk("model_iact_cnt", 128'(iact_vec_cnt), 128'(m_icnt));
        chk("model_weight_cnt", 128'(weight_vec_cnt), 128'(m_wcnt));
    endtask

    task automatic model_step();
        logic acc_i, acc_w, xfer_i, xfer_w;
        if (rst) begin
            m_iq.delete();
            m_wq.delete();
            m_ipend = 1'b0;
            m_wpend = 1'b0;
            m_icnt  = 0;
            m_wcnt  = 0;
            return;
        end
        acc_i  = in_valid && !in_sel && !flush && !m_ipend;
        acc_w  = in_valid && in_sel && !flush && !m_wpend;
        xfer_i = m_ipend && iact_buffer_ready;
        xfer_w = m_wpend && weight_buffer_ready;
        if (flush) begin
            m_iq.delete();
            m_wq.delete();
        end
        if (xfer_i) begin
            m_ipend = 1'b0;
            m_icnt  = (m_icnt + 1) % (1 << CW);
        end
        if (xfer_w) begin
            m_wpend = 1'b0;
            m_wcnt  = (m_wcnt + 1) % (1 << CW);
        end
        if (acc_i) begin
            m_iq.push_back(in_data);
            if (m_iq.size() == IC) begin
                for (int k = 0; k < IC; k++) m_ivec[k*DW +: DW] = m_iq[k];
                m_ipend = 1'b1;
                m_iq.delete();
            end
        end
        if (acc_w) begin
            m_wq.push_back(in_data);
            if (m_wq.size() == AW) begin
                for (int k = 0; k < AW; k++) m_wvec[k*DW +: DW] = m_wq[k];
                m_wpend = 1'b1;
                m_wq.delete();
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic word(input logic sel, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    typedef struct {
        logic          v, s, fl, ir, wr;
        logic [DW-1:0] d;
        logic          e_rdy, e_iwe, e_wwe;
        logic [CW-1:0] e_icnt, e_wcnt;
        logic [DW*IC-1:0] e_ibus;
        logic [DW*AW-1:0] e_wbus;
    } row_t;

    function automatic row_t mk(input logic v, input logic s, input logic [DW-1:0] d,
                                input logic ir, input logic wr, input logic e_rdy,
                                input logic e_iwe, input logic e_wwe, input logic [CW-1:0] e_icnt,
                                input logic [CW-1:0] e_wcnt);
        row_t r;
        r.v = v; r.s = s; r.d = d; r.fl = 1'b0; r.ir = ir; r.wr = wr;
        r.e_rdy = e_rdy; r.e_iwe = e_iwe; r.e_wwe = e_wwe;
        r.e_icnt = e_icnt; r.e_wcnt = e_wcnt;
        r.e_ibus = 80'h0005_0004_0003_0002_0001;
        r.e_wbus = 48'h000C_000B_000A;
        return r;
    endfunction

    row_t tbl[16];

    initial begin
        m_ipend = 1'b0; m_wpend = 1'b0; m_icnt = 0; m_wcnt = 0;
        m_ivec = '0; m_wvec = '0;
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hFFFF; flush = 1'b0;
        iact_buffer_ready = 1'b1; weight_buffer_ready = 1'b1;

        // Reset: first edge establishes state, second cycle checks in_ready held low in rst.
        @(posedge clk);
        model_step();
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        tick();
        rst = 1'b0; in_valid = 1'b0; iact_buffer_ready = 1'b0; weight_buffer_ready = 1'b0;
        #1;
        chk("rst_iwe", 128'(iact_write_en), 128'(0));
        chk("rst_wwe", 128'(weight_write_en), 128'(0));
        chk("rst_ibus", 128'(data_iact_out), 128'(0));
        chk("rst_wbus", 128'(data_weight_out), 128'(0));
        chk("rst_icnt", 128'(iact_vec_cnt), 128'(0));
        chk("rst_wcnt", 128'(weight_vec_cnt), 128'(0));
        chk("post_rst_ready", 128'(in_ready), 128'(1));

        // Directed table: five iacts then a weight vector stalled four cycles.
        tbl[0]  = mk(1, 0, 16'h1, 1, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 16'h2, 1, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 16'h3, 1, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 16'h4, 1, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 16'h5, 1, 0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 16'h0, 1, 0, 0, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 16'h0, 1, 0, 1, 0, 0, 1, 0);
        tbl[7]  = mk(1, 1, 16'hA, 0, 0, 1, 0, 0, 1, 0);
        tbl[8]  = mk(1, 1, 16'hB, 0, 0, 1, 0, 0, 1, 0);
        tbl[9]  = mk(1, 1, 16'hC, 0, 0, 1, 0, 0, 1, 0);
        tbl[10] = mk(1, 1, 16'hD, 0, 0, 0, 0, 1, 1, 0);
        tbl[11] = mk(1, 1, 16'hD, 0, 0, 0, 0, 1, 1, 0);
        tbl[12] = mk(1, 1, 16'hD, 0, 0, 0, 0, 1, 1, 0);
        tbl[13] = mk(1, 1, 16'hD, 0, 0, 0, 0, 1, 1, 0);
        tbl[14] = mk(0, 1, 16'h0, 0, 1, 0, 0, 1, 1, 0);
        tbl[15] = mk(0, 1, 16'h0, 0, 0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 16; i++) begin
            in_valid = tbl[i].v; in_sel = tbl[i].s; in_data = tbl[i].d; flush = tbl[i].fl;
            iact_buffer_ready = tbl[i].ir; weight_buffer_ready = tbl[i].wr;
            #1;
            chk($sformatf("tbl%0d_ready", i), 128'(in_ready), 128'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_iwe", i), 128'(iact_write_en), 128'(tbl[i].e_iwe));
            chk($sformatf("tbl%0d_wwe", i), 128'(weight_write_en), 128'(tbl[i].e_wwe));
            chk($sformatf("tbl%0d_icnt", i), 128'(iact_vec_cnt), 128'(tbl[i].e_icnt));
            chk($sformatf("tbl%0d_wcnt", i), 128'(weight_vec_cnt), 128'(tbl[i].e_wcnt));
            if (tbl[i].e_iwe)
                chk($sformatf("tbl%0d_ibus", i), 128'(data_iact_out), 128'(tbl[i].e_ibus));
            if (tbl[i].e_wwe)
                chk($sformatf("tbl%0d_wbus", i), 128'(data_weight_out), 128'(tbl[i].e_wbus));
            tick();
        end

        // Stalled weight vector must not block an iact vector.
        iact_buffer_ready = 1'b0; weight_buffer_ready = 1'b0;
        for (int i = 0; i < AW; i++) word(1'b1, DW'(16'h21 + i));
        for (int i = 0; i < IC; i++) word(1'b0, DW'(16'h31 + i));
        chk("indep_iwe", 128'(iact_write_en), 128'(1));
        chk("indep_wwe", 128'(weight_write_en), 128'(1));
        chk("indep_ibus", 128'(data_iact_out), 128'(80'h0035_0034_0033_0032_0031));
        iact_buffer_ready = 1'b1;
        idle();
        chk("indep_iwe_done", 128'(iact_write_en), 128'(0));
        chk("indep_wwe_pending", 128'(weight_write_en), 128'(1));
        iact_buffer_ready = 1'b0; weight_buffer_ready = 1'b1;
        idle();
        weight_buffer_ready = 1'b0;

        // Flush discards a partial iact vector.
        word(1'b0, 16'h7);
        word(1'b0, 16'h8);
        flush = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h9;
        #1;
        chk("flush_ready", 128'(in_ready), 128'(0));
        tick();
        flush = 1'b0;
        for (int i = 0; i < IC; i++) word(1'b0, DW'(16'h10 + i));
        chk("flush_iwe", 128'(iact_write_en), 128'(1));
        chk("flush_ibus", 128'(data_iact_out), 128'(80'h0014_0013_0012_0011_0010));
        iact_buffer_ready = 1'b1;
        idle();

        // Reset while a vector is pending drops it uncounted.
        iact_buffer_ready = 1'b0;
        for (int i = 0; i < IC; i++) word(1'b0, DW'(16'h41 + i));
        chk("rstp_iwe_before", 128'(iact_write_en), 128'(1));
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("rstp_iwe", 128'(iact_write_en), 128'(0));
        chk("rstp_icnt", 128'(iact_vec_cnt), 128'(0));
        chk("rstp_wcnt", 128'(weight_vec_cnt), 128'(0));
        iact_buffer_ready = 1'b1;
        for (int i = 0; i < IC; i++) word(1'b0, DW'(16'h51 + i));
        idle();
        chk("rstp_icnt_after", 128'(iact_vec_cnt), 128'(1));

        // Counter wrap after 256 transfers.
        rst = 1'b1;
        idle();
        rst = 1'b0;
        iact_buffer_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            for (int i = 0; i < IC; i++) word(1'b0, DW'(v * 8 + i));
            idle();
            if (v == 254) chk("wrap_255", 128'(iact_vec_cnt), 128'(255));
        end
        chk("wrap_0", 128'(iact_vec_cnt), 128'(0));

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst                 = ($urandom_range(0, 199) == 0);
            in_valid            = ($urandom_range(0, 9) < 7);
            in_sel              = 1'($urandom_range(0, 1));
            in_data             = DW'($urandom);
            flush               = ($urandom_range(0, 19) == 0);
            iact_buffer_ready   = 1'($urandom_range(0, 1));
            weight_buffer_ready = 1'($urandom_range(0, 1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
